// File: rtl/seg595_pkg.sv
// Shared constants, state type and helpers for the 74HC595 dynamic 7-segment driver.
package seg595_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Common anode, active-low {dp, g..a}; entry n sits at bits [8n +: 8].
    localparam logic [127:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } shift_state_e;

    function automatic logic [7:0] digit2seg(input logic [3:0] d);
        return SEG_TABLE[{d, 3'b000} +: 8];
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Decimal digits needed to hold any w-bit unsigned value.
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned max_v;
        int unsigned     n;
        max_v = (64'd1 << w) - 64'd1;
        n     = 1;
        for (int unsigned i = 1; i < 20; i++) begin
            if (pow10(i) <= max_v) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle, DATA_W steps.
module bin2bcd_seq
    import seg595_pkg::*;
#(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    // At least one digit above the displayed ones so overflow is always observable.
    localparam int unsigned NumBcd = (bcd_digits(DATA_W) > DIGITS) ? bcd_digits(DATA_W)
                                                                    : DIGITS + 1;
    localparam int unsigned CntW   = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [4*NumBcd-1:0] bcd_q, bcd_d;
    logic [4*NumBcd-1:0] adj;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj    = bcd_q;
        if (busy_q) begin
            for (int i = 0; i < int'(NumBcd); i++) begin
                if (adj[4*i +: 4] >= 4'd5) begin
                    adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
            end
            bcd_d = {adj[4*NumBcd-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = CntW'(DATA_W);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q[4*DIGITS-1:0];
    assign ovf_o  = |bcd_q[4*NumBcd-1:4*DIGITS];

endmodule

// File: rtl/seg595_dynamic_param.sv
// Dynamic 7-segment driver: handshake capture, BCD decode with blanking/sign,
// display buffer and time-multiplexed serial output to a 74HC595 chain.
module seg595_dynamic_param
    import seg595_pkg::*;
#(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned DATA_W      = 20,
    parameter int unsigned SCAN_CYCLES = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data,
    input  logic [DIGITS-1:0] point,
    input  logic              sign,
    input  logic              data_vld,
    output logic              data_rdy,
    input  logic              seg_en,
    output logic              shcp,
    output logic              stcp,
    output logic              ds,
    output logic              oe
);

    localparam int unsigned WordW = DIGITS + 8;
    localparam int unsigned CntW  = $clog2(SCAN_CYCLES);
    localparam int unsigned IdxW  = $clog2(DIGITS);
    localparam int unsigned BitW  = $clog2(WordW);

    // Capture and conversion
    logic                conv_q, conv_d;
    logic [DIGITS-1:0]   point_q;
    logic                sign_q;
    logic                capture;
    logic                conv_busy, conv_done, conv_ovf;
    logic [4*DIGITS-1:0] bcd;

    assign data_rdy = ~conv_q;
    assign capture  = data_vld & ~conv_q & ~conv_busy;

    always_comb begin
        conv_d = conv_q;
        if (capture) begin
            conv_d = 1'b1;
        end else if (conv_done) begin
            conv_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            conv_q  <= 1'b0;
            point_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            conv_q <= conv_d;
            if (capture) begin
                point_q <= point;
                sign_q  <= sign;
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .start_i (capture),
        .bin_i   (data),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (bcd),
        .ovf_o   (conv_ovf)
    );

    // Blanking and sign placement
    logic [IdxW-1:0] msd;
    logic [7:0]      dec [DIGITS];

    always_comb begin
        msd = '0;
        for (int i = 1; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd0 || point_q[i]) begin
                msd = IdxW'(i);
            end
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (conv_ovf) begin
                dec[i] = SEG_MINUS;
            end else if (IdxW'(i) <= msd) begin
                dec[i] = digit2seg(bcd[4*i +: 4]);
                if (point_q[i]) begin
                    dec[i][7] = 1'b0;
                end
            end else if (sign_q && IdxW'(i) == msd + 1'b1) begin
                dec[i] = SEG_MINUS;
            end else begin
                dec[i] = SEG_BLANK;
            end
        end
    end

    logic [7:0] disp_q [DIGITS];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                disp_q[i] <= SEG_BLANK;
            end
        end else if (conv_done) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                disp_q[i] <= dec[i];
            end
        end
    end

    // Slot counter and digit index
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            slot_end;

    assign slot_end = (cnt_q == CntW'(SCAN_CYCLES - 1));

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Shift FSM; the whole word is snapshotted at slot start so buffer writes never tear it.
    shift_state_e      state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WordW-1:0]  word_q, word_d;
    logic [DIGITS-1:0] sel;

    assign sel = DIGITS'(1) << idx_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        word_d  = word_q;
        unique case (state_q)
            StIdle: begin
                if (cnt_q == '0) begin
                    state_d = StShift;
                    phase_d = 2'd0;
                    bit_d   = '0;
                    word_d  = {disp_q[idx_q], sel};
                end
            end
            StShift: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (bit_q == BitW'(WordW - 1)) begin
                        state_d = StLatch;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        word_d = word_q >> 1;
                    end
                end
            end
            StLatch: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic shcp_q, stcp_q, ds_q, oe_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StIdle;
            phase_q <= 2'd0;
            bit_q   <= '0;
            word_q  <= '0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            oe_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            shcp_q  <= (state_d == StShift) & phase_d[1];
            stcp_q  <= (state_d == StLatch);
            ds_q    <= (state_d == StShift) & word_d[0];
            oe_q    <= ~seg_en;
        end
    end

    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign ds   = ds_q;
    assign oe   = oe_q;

endmodule

// File: tb/tb_seg595_dynamic_param.sv
// Bench for seg595_dynamic_param: table of loads, scoreboard of latched words, reset corners.
module tb_seg595_dynamic_param;

    localparam int D1    = 6;
    localparam int DW1   = 20;
    localparam int SCAN1 = 60;
    localparam int W1    = D1 + 8;
    localparam int D2    = 8;
    localparam int DW2   = 27;
    localparam int SCAN2 = 70;

    logic           sys_clk, sys_rst, seg_en;
    logic [DW1-1:0] data;
    logic [D1-1:0]  point;
    logic           sign, data_vld, data_rdy, shcp, stcp, ds, oe;
    logic [DW2-1:0] data2;
    logic [D2-1:0]  point2;
    logic           sign2, vld2, rdy2, shcp2, stcp2, ds2, oe2;

    seg595_dynamic_param #(
        .DIGITS      (D1),
        .DATA_W      (DW1),
        .SCAN_CYCLES (SCAN1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .data_vld (data_vld),
        .data_rdy (data_rdy),
        .seg_en   (seg_en),
        .shcp     (shcp),
        .stcp     (stcp),
        .ds       (ds),
        .oe       (oe)
    );

    seg595_dynamic_param #(
        .DIGITS      (D2),
        .DATA_W      (DW2),
        .SCAN_CYCLES (SCAN2)
    ) dut8 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .data     (data2),
        .point    (point2),
        .sign     (sign2),
        .data_vld (vld2),
        .data_rdy (rdy2),
        .seg_en   (seg_en),
        .shcp     (shcp2),
        .stcp     (stcp2),
        .ds       (ds2),
        .oe       (oe2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW1-1:0] data;
        logic [D1-1:0]  point;
        logic           sign;
        logic [47:0]    segs;   // {digit5 .. digit0}
    } vec_t;

    typedef struct {
        logic [7:0] seg;
        int         digit;
        int         vec;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   mon_idx = 0;
    int   mon_nshcp = 0;
    int   stcp_cnt = 0;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reassemble each latched word and score it.
    initial begin : monitor
        logic [W1-1:0] word;
        logic          shcp_prev, stcp_prev;
        int            cyc, last;
        bit            have_last;
        exp_t          e;
        word = '0; shcp_prev = 1'b0; stcp_prev = 1'b0; cyc = 0; last = 0; have_last = 0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (sys_rst) begin
                word = '0; shcp_prev = 1'b0; stcp_prev = 1'b0;
                mon_nshcp = 0; mon_idx = 0; have_last = 0;
            end else begin
                if (shcp && !shcp_prev) begin
                    word = {ds, word[W1-1:1]};
                    mon_nshcp++;
                end
                if (stcp) begin
                    chk("stcp_single_cycle", stcp_prev, 0);
                    chk("shcp_per_slot", mon_nshcp, W1);
                    chk("ds_low_at_latch", ds, 0);
                    chk("scan_sel", word[D1-1:0], 1 << mon_idx);
                    if (have_last) chk("slot_period", cyc - last, SCAN1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("vec%0d_digit%0d_seg", e.vec, e.digit), word[W1-1:D1], e.seg);
                    end
                    last = cyc; have_last = 1; mon_nshcp = 0;
                    mon_idx = (mon_idx + 1) % D1;
                    stcp_cnt++;
                end
                shcp_prev = shcp;
                stcp_prev = stcp;
            end
        end
    end

    task automatic wait_stcp();
        int c0, n;
        c0 = stcp_cnt; n = 0;
        while (stcp_cnt == c0 && n < 4 * SCAN1) begin @(negedge sys_clk); n++; end
        chk("stcp_seen", stcp_cnt != c0, 1);
    endtask

    // Skip one latch (may carry the stale word), then expect every digit once.
    task automatic expect_display(input logic [47:0] segs, input int vid);
        int n;
        wait_stcp();
        for (int k = 0; k < D1; k++) begin
            int d;
            d = (mon_idx + k) % D1;
            exp_q.push_back('{seg: segs[8*d +: 8], digit: d, vec: vid});
        end
        n = 0;
        while (exp_q.size() > 0 && n < 2 * D1 * SCAN1) begin @(negedge sys_clk); n++; end
        chk($sformatf("vec%0d_drained", vid), exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load(input logic [DW1-1:0] d, input logic [D1-1:0] p, input logic s);
        int n;
        @(negedge sys_clk);
        data = d; point = p; sign = s; data_vld = 1'b1;
        @(negedge sys_clk);
        data = ~d; point = ~p; sign = ~s;   // must be ignored while busy
        n = 0;
        while (!data_rdy && n < 100) begin n++; @(negedge sys_clk); end
        data_vld = 1'b0;
        chk("rdy_low_cycles", n, DW1 + 1);
    endtask

    // Called right after a negedge on which reset was released.
    task automatic check_restart();
        int n;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!shcp && n < 200);
        chk("first_shcp_delay", n, 3);
        while (!stcp && n < 200) begin @(negedge sys_clk); n++; end
        chk("first_stcp_delay", n, 4 * W1 + 1);
    endtask

    task automatic grab2(output logic [15:0] w, output bit ok);
        logic prev;
        int   n;
        prev = shcp2; n = 0; w = '0; ok = 0;
        while (!ok && n < 4 * SCAN2) begin
            @(negedge sys_clk);
            n++;
            if (shcp2 && !prev) w = {ds2, w[15:1]};
            prev = shcp2;
            if (stcp2) ok = 1;
        end
    endtask

    initial begin : main
        logic [15:0] w;
        logic [7:0]  mask;
        bit          ok;
        int          n;

        vecs[0] = '{20'd123456,  6'b000100, 1'b0, 48'hF9_A4_B0_19_92_82};
        vecs[1] = '{20'd42,      6'b000000, 1'b1, 48'hFF_FF_FF_BF_99_A4};
        vecs[2] = '{20'd1000000, 6'b000000, 1'b0, 48'hBF_BF_BF_BF_BF_BF};
        vecs[3] = '{20'd0,       6'b000000, 1'b0, 48'hFF_FF_FF_FF_FF_C0};
        vecs[4] = '{20'd999999,  6'b100000, 1'b1, 48'h10_90_90_90_90_90};
        vecs[5] = '{20'd7,       6'b001000, 1'b1, 48'hFF_BF_40_C0_C0_F8};
        vecs[6] = '{20'd1048575, 6'b111111, 1'b1, 48'hBF_BF_BF_BF_BF_BF};
        vecs[7] = '{20'd5,       6'b000000, 1'b1, 48'hFF_FF_FF_FF_BF_92};
        vecs[8] = '{20'd100000,  6'b000001, 1'b0, 48'hF9_C0_C0_C0_C0_40};

        sys_rst = 1'b1; seg_en = 1'b0;
        data = '0; point = '0; sign = 1'b0; data_vld = 1'b0;
        data2 = '0; point2 = '0; sign2 = 1'b0; vld2 = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_shcp", shcp, 0);
        chk("rst_stcp", stcp, 0);
        chk("rst_ds", ds, 0);
        chk("rst_oe", oe, 1);
        chk("rst_rdy", data_rdy, 1);
        chk("rst_rdy8", rdy2, 1);
        sys_rst = 1'b0; seg_en = 1'b1;
        check_restart();
        chk("oe_enabled", oe, 0);
        expect_display(48'hFF_FF_FF_FF_FF_FF, 99);

        for (int v = 0; v < 9; v++) begin
            load(vecs[v].data, vecs[v].point, vecs[v].sign);
            expect_display(vecs[v].segs, v);
        end

        seg_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("oe_disabled", oe, 1);
        seg_en = 1'b1;
        @(negedge sys_clk);
        chk("oe_reenabled", oe, 0);

        // Reset in the middle of bit 5 of a shift, with data_vld held.
        wait_stcp();
        n = 0;
        while (mon_nshcp < 6 && n < 4 * SCAN1) begin @(negedge sys_clk); n++; end
        chk("bit5_reached", mon_nshcp >= 6, 1);
        sys_rst = 1'b1; data_vld = 1'b1; data = 20'd777; point = '1; sign = 1'b1;
        #1;
        chk("midrst_shcp", shcp, 0);
        chk("midrst_stcp", stcp, 0);
        chk("midrst_ds", ds, 0);
        chk("midrst_oe", oe, 1);
        chk("midrst_rdy", data_rdy, 1);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0; data_vld = 1'b0;
        check_restart();
        chk("post_rst_rdy", data_rdy, 1);
        expect_display(48'hFF_FF_FF_FF_FF_FF, 100);

        // Eight-digit build: largest displayable value, no overflow.
        @(negedge sys_clk);
        data2 = 27'd99999999; vld2 = 1'b1;
        @(negedge sys_clk);
        data2 = '1;
        n = 0;
        while (!rdy2 && n < 100) begin n++; @(negedge sys_clk); end
        vld2 = 1'b0;
        chk("d8_rdy_low_cycles", n, DW2 + 1);
        mask = '0;
        for (int k = 0; k < D2 + 1; k++) begin
            grab2(w, ok);
            if (k > 0) begin
                chk("d8_word_seen", ok, 1);
                chk($sformatf("d8_sel%0h_seg", w[7:0]), w[15:8], 8'h90);
                mask |= w[7:0];
            end
        end
        chk("d8_all_digits_scanned", mask, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
